// File: rtl/sprite_pkg.sv
// Shared widths, FSM state encoding and line-buffer word layout for the sprite line writer.
package sprite_pkg;

  localparam int unsigned SPR_W     = 16;
  localparam int unsigned SPR_BYTES = SPR_W / 2;
  localparam int unsigned LB_XW     = 9;
  localparam int unsigned LB_AW     = LB_XW + 1;
  localparam int unsigned PIX_W     = 4;
  localparam int unsigned PAL_W     = 4;
  localparam int unsigned ROM_DW    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAW  = 2'd2
  } state_t;

  // One line-buffer entry: palette in the high nibble, pixel index in the low nibble.
  typedef struct packed {
    logic [PAL_W-1:0] pal;
    logic [PIX_W-1:0] pix;
  } lb_word_t;

endpackage

// File: rtl/spr_pix_serializer.sv
// Turns one pattern byte into two 4bpp pixels over two cycles, honouring horizontal flip.
module spr_pix_serializer
  import sprite_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flip,
  input  logic [ROM_DW-1:0] din,
  output logic [PIX_W-1:0]  pix_c,
  output logic              opaque_c
);

  logic [ROM_DW-1:0] held;

  always_ff @(posedge clk) begin
    if (rst) begin
      held <= '0;
    end else if (load) begin
      held <= din;
    end
  end

  // First pixel comes straight off the ROM bus; the second from the captured byte.
  always_comb begin
    pix_c = '0;
    if (load) begin
      pix_c = flip ? din[7:4] : din[3:0];
    end else begin
      pix_c = flip ? held[3:0] : held[7:4];
    end
  end

  assign opaque_c = |pix_c;

endmodule

// File: rtl/sprite_line_writer.sv
// Renders one 16-pixel sprite row per command into the line-buffer write port.
// Optional build macro SPR_XCLIP_EN suppresses writes to x >= 256.
module sprite_line_writer
  import sprite_pkg::*;
#(
  parameter int unsigned RAW = 15,
  parameter int unsigned SPW = SPR_W
) (
  input  logic                 CL,
  input  logic                 RESET,
  input  logic                 LBANK,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic [LB_XW-1:0]     CMD_X,
  input  logic [PAL_W-1:0]     CMD_PAL,
  input  logic                 CMD_FLIP,
  input  logic [RAW-1:0]       CMD_BASE,
  output logic [RAW-1:0]       ROM_AD,
  input  logic [ROM_DW-1:0]    ROM_DT,
  output logic [LB_AW-1:0]     LB_AD,
  output logic                 LB_WE,
  output logic [ROM_DW-1:0]    LB_WD,
  output logic                 BUSY
);

  localparam int unsigned CW = $clog2(SPW);

  state_t             state, state_nx;
  logic [CW-1:0]      k;
  logic [LB_XW-1:0]   x_q;
  logic [PAL_W-1:0]   pal_q;
  logic               flip_q;
  logic               bank_q;

  logic               accept_c;
  logic               last_c;
  logic               ready_nx_c;
  logic               load_c;
  logic [PIX_W-1:0]   pix_c;
  logic               opaque_c;
  logic               clip_c;
  logic [LB_XW-1:0]   px_c;
  lb_word_t           wd_c;

  assign accept_c = CMD_VALID && CMD_READY;
  assign last_c   = (k == CW'(SPW - 1));
  assign load_c   = (state == DRAW) && !k[0];
  assign px_c     = x_q + LB_XW'(k);
  assign wd_c     = '{pal: pal_q, pix: pix_c};

`ifdef SPR_XCLIP_EN
  assign clip_c = px_c[LB_XW-1];
`else
  assign clip_c = 1'b0;
`endif

  // Next state; ready is held low for the cycle the FSM returns to IDLE.
  always_comb begin
    state_nx   = state;
    ready_nx_c = 1'b0;
    case (state)
      IDLE:    if (accept_c) state_nx = FETCH;
      FETCH:   state_nx = DRAW;
      DRAW:    if (last_c) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    ready_nx_c = (state == IDLE) && (state_nx == IDLE);
  end

  always_ff @(posedge CL) begin
    if (RESET) begin
      state     <= IDLE;
      CMD_READY <= 1'b0;
      BUSY      <= 1'b1;
    end else begin
      state     <= state_nx;
      CMD_READY <= ready_nx_c;
      BUSY      <= !ready_nx_c;
    end
  end

  // Command latch, pixel counter and ROM address stepping (one byte per two pixels).
  always_ff @(posedge CL) begin
    if (RESET) begin
      x_q    <= '0;
      pal_q  <= '0;
      flip_q <= 1'b0;
      bank_q <= 1'b0;
      k      <= '0;
      ROM_AD <= '0;
    end else if (accept_c) begin
      x_q    <= CMD_X;
      pal_q  <= CMD_PAL;
      flip_q <= CMD_FLIP;
      bank_q <= LBANK;
      k      <= '0;
      ROM_AD <= CMD_FLIP ? CMD_BASE + RAW'(SPW / 2 - 1) : CMD_BASE;
    end else if (state == DRAW) begin
      k <= k + CW'(1);
      if (!k[0] && (k != CW'(SPW - 2))) begin
        ROM_AD <= flip_q ? ROM_AD - RAW'(1) : ROM_AD + RAW'(1);
      end
    end
  end

  // Line-buffer port: address and data track every pixel, enable only for visible ones.
  always_ff @(posedge CL) begin
    if (RESET) begin
      LB_AD <= '0;
      LB_WE <= 1'b0;
      LB_WD <= '0;
    end else if (state == DRAW) begin
      LB_AD <= {bank_q, px_c};
      LB_WE <= opaque_c && !clip_c;
      LB_WD <= wd_c;
    end else begin
      LB_WE <= 1'b0;
    end
  end

  spr_pix_serializer u_ser (
    .clk      (CL),
    .rst      (RESET),
    .load     (load_c),
    .flip     (flip_q),
    .din      (ROM_DT),
    .pix_c    (pix_c),
    .opaque_c (opaque_c)
  );

endmodule

// File: tb/tb_sprite_line_writer.sv
// Scoreboard bench for sprite_line_writer: driver queues expected line-buffer activity, monitor checks it.
module tb_sprite_line_writer;

  logic        CL = 1'b0;
  logic        RESET;
  logic        LBANK;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [8:0]  CMD_X;
  logic [3:0]  CMD_PAL;
  logic        CMD_FLIP;
  logic [14:0] CMD_BASE;
  logic [14:0] ROM_AD;
  logic [7:0]  ROM_DT;
  logic [9:0]  LB_AD;
  logic        LB_WE;
  logic [7:0]  LB_WD;
  logic        BUSY;

  always #5 CL = ~CL;

  sprite_line_writer dut (
    .CL        (CL),
    .RESET     (RESET),
    .LBANK     (LBANK),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_X     (CMD_X),
    .CMD_PAL   (CMD_PAL),
    .CMD_FLIP  (CMD_FLIP),
    .CMD_BASE  (CMD_BASE),
    .ROM_AD    (ROM_AD),
    .ROM_DT    (ROM_DT),
    .LB_AD     (LB_AD),
    .LB_WE     (LB_WE),
    .LB_WD     (LB_WD),
    .BUSY      (BUSY)
  );

  logic [7:0] rom [0:32767];
  always @(posedge CL) ROM_DT <= rom[ROM_AD];

  int cyc = 0;
  always @(posedge CL) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       we;
    logic [9:0] ad;
    logic [7:0] wd;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic mon_on = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: pixel slots must match the queue head; all other cycles must not write.
  always @(negedge CL) begin
    exp_t e;
    if (mon_on) begin
      if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk("lb_slot_cycle", 32'(cyc), 32'(e.cyc));
        chk("lb_we", 32'(LB_WE), 32'(e.we));
        chk("lb_ad", 32'(LB_AD), 32'(e.ad));
        chk("lb_wd", 32'(LB_WD), 32'(e.wd));
      end else begin
        chk("idle_lb_we", 32'(LB_WE), 32'(0));
      end
    end
  end

  task automatic load_rom(input logic [14:0] base, input logic [63:0] row);
    for (int n = 0; n < 8; n++) rom[15'(base + 15'(n))] = row[8*n +: 8];
  endtask

  // Reference model of one row: pixel k appears at a+3+k.
  function automatic void expect_row(input logic [8:0] x, input logic [3:0] pal, input logic flip,
                                     input logic [14:0] base, input logic bank, input int a,
                                     input int npix);
    for (int k = 0; k < npix; k++) begin
      int         n;
      logic [7:0] b;
      logic [3:0] nib;
      logic [8:0] px;
      exp_t       e;
      n   = flip ? 7 - k / 2 : k / 2;
      b   = rom[15'(base + 15'(n))];
      nib = (flip ^ k[0]) ? b[7:4] : b[3:0];
      px  = 9'(x + 9'(k));
      e.cyc = a + 3 + k;
      e.we  = (nib != 4'd0);
`ifdef SPR_XCLIP_EN
      if (px >= 9'd256) e.we = 1'b0;
`endif
      e.ad = {bank, px};
      e.wd = {pal, nib};
      exp_q.push_back(e);
    end
  endfunction

  // Present a command at a negedge and wait (bounded) for it to be accepted; a = accept cycle.
  task automatic send(input logic [8:0] x, input logic [3:0] pal, input logic flip,
                      input logic [14:0] base, input logic bank, input int npix, output int a);
    CMD_X = x; CMD_PAL = pal; CMD_FLIP = flip; CMD_BASE = base; LBANK = bank;
    CMD_VALID = 1'b1;
    a = -1;
    for (int t = 0; t < 100; t++) begin
      if (CMD_READY === 1'b1) begin
        a = cyc;
        break;
      end
      @(negedge CL);
    end
    if (a < 0) begin
      chk("accept_timeout", 32'(CMD_READY), 32'(1));
      a = cyc;
    end else begin
      expect_row(x, pal, flip, base, bank, a, npix);
    end
    @(negedge CL);
  endtask

  // Follow one row to completion, checking ROM addressing and ready timing.
  task automatic finish_row(input int a, input logic flip, input logic [14:0] base,
                            input logic scramble);
    while (cyc < a + 20) begin
      if (cyc == a + 1)  chk("rom_ad_first", 32'(ROM_AD), flip ? 32'(base) + 7 : 32'(base));
      if (cyc == a + 15) chk("rom_ad_last", 32'(ROM_AD), flip ? 32'(base) : 32'(base) + 7);
      if (cyc == a + 18) chk("ready_last_pixel", 32'(CMD_READY), 32'(0));
      if (cyc == a + 19) chk("ready_after_row", 32'(CMD_READY), 32'(1));
      if (scramble) begin
        LBANK    = ~LBANK;
        CMD_X    = 9'($urandom);
        CMD_PAL  = 4'($urandom);
        CMD_FLIP = 1'($urandom);
        CMD_BASE = 15'($urandom);
      end
      @(negedge CL);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int a, a1, a2, a3;
    foreach (rom[i]) rom[i] = 8'h00;
    RESET = 1'b1; LBANK = 1'b0; CMD_VALID = 1'b0; CMD_X = '0; CMD_PAL = '0;
    CMD_FLIP = 1'b0; CMD_BASE = '0;

    repeat (3) @(negedge CL);
    chk("rst_ready", 32'(CMD_READY), 32'(0));
    chk("rst_busy", 32'(BUSY), 32'(1));
    chk("rst_lb_we", 32'(LB_WE), 32'(0));
    chk("rst_rom_ad", 32'(ROM_AD), 32'(0));
    chk("rst_lb_ad", 32'(LB_AD), 32'(0));
    chk("rst_lb_wd", 32'(LB_WD), 32'(0));
    mon_on = 1'b1;
    RESET = 1'b0;
    chk("ready_release_cycle", 32'(CMD_READY), 32'(0));
    @(negedge CL);
    chk("ready_after_release", 32'(CMD_READY), 32'(1));
    chk("busy_after_release", 32'(BUSY), 32'(0));

    // Row 1: pixels 1..15 then a transparent 0, written to 0x210.. with palette 5.
    load_rom(15'h100, 64'h0FED_CBA9_8765_4321);
    send(9'd16, 4'd5, 1'b0, 15'h100, 1'b1, 16, a);
    CMD_VALID = 1'b0;
    finish_row(a, 1'b0, 15'h100, 1'b1);

    // Same row flipped.
    send(9'd16, 4'd5, 1'b1, 15'h100, 1'b1, 16, a);
    CMD_VALID = 1'b0;
    finish_row(a, 1'b1, 15'h100, 1'b1);

    // Mostly transparent pattern.
    load_rom(15'h200, 64'h00F0_00F0_00F0_00F0);
    send(9'd100, 4'd3, 1'b0, 15'h200, 1'b0, 16, a);
    CMD_VALID = 1'b0;
    finish_row(a, 1'b0, 15'h200, 1'b1);

    // Horizontal wrap at x = 0x1F8.
    load_rom(15'h300, 64'h8877_6655_4433_2211);
    send(9'h1F8, 4'hA, 1'b0, 15'h300, 1'b0, 16, a);
    CMD_VALID = 1'b0;
    finish_row(a, 1'b0, 15'h300, 1'b1);

    // Three commands with valid held high.
    load_rom(15'h400, 64'h1234_5678_9ABC_DEF1);
    load_rom(15'h500, 64'hF0E1_D2C3_B4A5_9687);
    load_rom(15'h600, 64'h3300_0033_7007_1111);
    send(9'd0,   4'd1, 1'b0, 15'h400, 1'b0, 16, a1);
    send(9'd300, 4'd2, 1'b1, 15'h500, 1'b1, 16, a2);
    send(9'd500, 4'd9, 1'b0, 15'h600, 1'b0, 16, a3);
    CMD_VALID = 1'b0;
    chk("b2b_gap_1", 32'(a2 - a1), 32'(19));
    chk("b2b_gap_2", 32'(a3 - a2), 32'(19));
    finish_row(a3, 1'b0, 15'h600, 1'b0);

    // Reset in the middle of a row: pixels 0..5 land, nothing after.
    send(9'd40, 4'd7, 1'b0, 15'h100, 1'b1, 6, a);
    CMD_VALID = 1'b0;
    while (cyc < a + 8) @(negedge CL);
    RESET = 1'b1;
    @(negedge CL);
    chk("midrst_ready_a9", 32'(CMD_READY), 32'(0));
    chk("midrst_lb_we_a9", 32'(LB_WE), 32'(0));
    @(negedge CL);
    RESET = 1'b0;
    chk("midrst_ready_a10", 32'(CMD_READY), 32'(0));
    @(negedge CL);
    chk("midrst_ready_a11", 32'(CMD_READY), 32'(1));
    send(9'd200, 4'd2, 1'b1, 15'h300, 1'b0, 16, a);
    CMD_VALID = 1'b0;
    finish_row(a, 1'b1, 15'h300, 1'b1);

    repeat (5) @(negedge CL);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
